// File: rtl/sm_fetch_queue.sv
// Instruction prefetch queue: drives the ROM word address, captures {pc, word, fault} into a small FIFO.
// Head visible one cycle after push; redirect flushes and restarts fetch, full queue stalls fetch unless popping.
module sm_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ROM_SIZE = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [31:0]                rom_addr,
  input  logic [31:0]                rom_rd,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic                       out_fault,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } entry_t;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  entry_t        mem_q [DEPTH];

  logic   pop;
  logic   push;
  logic   fetch_fault;
  entry_t wr_entry;
  entry_t head;
  logic   redirect_lsb_unused;

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  assign rom_addr    = {2'b00, fetch_pc_q[31:2]};
  assign fetch_fault = rom_addr >= 32'(ROM_SIZE);

  assign out_valid = (level_q != '0);
  assign pop       = out_valid & out_ready;
  assign push      = !redirect_valid & ((level_q < LW'(DEPTH)) | pop);

  // Out-of-range fetches carry a NOP so a stray consumer never executes ROM garbage.
  assign wr_entry.pc    = fetch_pc_q;
  assign wr_entry.instr = fetch_fault ? NOP : rom_rd;
  assign wr_entry.fault = fetch_fault;

  assign head      = mem_q[rd_ptr_q];
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_fault = out_valid ? head.fault : 1'b0;
  assign level     = level_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    if (redirect_valid) begin
      // A coincident pop is absorbed by the flush.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        level_d = level_q + LW'(1);
      end else if (pop && !push) begin
        level_d = level_q - LW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // Storage needs no reset: every output read of it is gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_sm_fetch_queue.sv
// Bench for sm_fetch_queue: directed phases plus random ready/redirect traffic against a queue-based model.
module tb_sm_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          ROM_SIZE = 128;
  localparam logic [31:0] JUNK     = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rom_addr;
  logic [31:0] rom_rd;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;
  logic [2:0]  level;

  logic [31:0] rom [ROM_SIZE];

  int n_vec = 0;
  int n_err = 0;

  ent_t        mq[$];
  logic [31:0] mpc;

  sm_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .ROM_SIZE(ROM_SIZE)) dut (
    .clk(clk), .rst(rst),
    .rom_addr(rom_addr), .rom_rd(rom_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_fault(out_fault),
    .level(level)
  );

  always #5 clk = ~clk;

  // Out-of-range reads return junk so NOP substitution is observable.
  assign rom_rd = (rom_addr < 32'(ROM_SIZE)) ? rom[rom_addr[6:0]] : JUNK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [29:0] idx);
    return (idx < 30'(ROM_SIZE)) ? rom[idx[6:0]] : JUNK;
  endfunction

  task automatic compare_all();
    logic [31:0] e_pc, e_instr;
    logic        e_fault;
    e_pc = '0; e_instr = '0; e_fault = 1'b0;
    if (mq.size() != 0) begin
      e_pc = mq[0].pc; e_instr = mq[0].instr; e_fault = mq[0].fault;
    end
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("level",     32'(level),     32'(mq.size()));
    check("out_pc",    out_pc,         e_pc);
    check("out_instr", out_instr,      e_instr);
    check("out_fault", 32'(out_fault), 32'(e_fault));
    check("rom_addr",  rom_addr,       {2'b00, mpc[31:2]});
  endtask

  // Predicts the state after the coming rising edge from the inputs now applied.
  task automatic model_edge();
    bit   pop, push;
    ent_t e;
    pop  = (mq.size() != 0) && out_ready;
    push = !redirect_valid && ((mq.size() < DEPTH) || pop);
    if (redirect_valid) begin
      mq.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc    = mpc;
        e.fault = (mpc[31:2] >= 30'(ROM_SIZE));
        e.instr = e.fault ? 32'h0000_0013 : rom_word(mpc[31:2]);
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    compare_all();
    rst            = 1'b0;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    model_edge();
  endtask

  task automatic rand_cycles(input int n);
    logic        rv;
    logic [31:0] rpc;
    for (int i = 0; i < n; i++) begin
      rv  = ($urandom_range(0, 99) < 8);
      rpc = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, ROM_SIZE * 4 + 64));
      step(($urandom_range(0, 99) < 65), rv, rpc);
    end
  endtask

  initial begin
    rom[0] = 32'h6140_0293;
    rom[1] = 32'h0800_0313;
    rom[2] = 32'h0053_2023;
    rom[3] = 32'h0003_2383;
    rom[4] = 32'h0000_0063;
    for (int i = 5; i < ROM_SIZE; i++) rom[i] = $urandom();
    mq.delete();
    mpc = RESET_PC;

    repeat (2) @(posedge clk);
    // Streaming with consumer always ready.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
    // Stall to fill, then drain with a pop every cycle while full.
    step(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
    // Three entries queued, then redirect with unaligned target.
    step(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h0000_000B);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
    // Cross the ROM boundary.
    step(1'b1, 1'b1, 32'h0000_01FC);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);
    // Back-to-back redirects, redirect with pop, and 32-bit PC wrap.
    step(1'b1, 1'b1, 32'h0000_0100);
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
    rand_cycles(300);

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_level", 32'(level),     32'd0);
    check("arst_pc",    out_pc,         32'd0);
    check("arst_instr", out_instr,      32'd0);
    check("arst_fault", 32'(out_fault), 32'd0);
    check("arst_addr",  rom_addr,       {2'b00, RESET_PC[31:2]});
    mq.delete();
    mpc = RESET_PC;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
    rand_cycles(300);
    step(1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
